icache_mshr: RTL and testbench

Miss-status holding register and memory-request sequencer for the instruction-cache fill path. Accepts up to two line requests per cycle (demand misses and prefetches) from the prefetcher and drops duplicates. Issues one memory load per cycle, demand first. Matches returning memory tags to outstanding entries and drives the single icache write port with the filled line. Sits between the prefetcher, the memory interface, and the icache inside `icache_subsystem`.

---
 rtl/icache_mshr.sv | 194 +++++++++++++++++++
 tb/tb_icache_mshr.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_mshr.sv
// Instruction-cache MSHR: dedups line requests, sequences memory loads
// demand-first, and turns tagged memory returns into icache fills.
module icache_mshr #(
    parameter int  NUM_ENTRIES  = 4,
    parameter int  NUM_MEM_TAGS = 15,
    parameter int  BLOCK_W      = 64,
    localparam int TAG_W        = $clog2(NUM_MEM_TAGS + 1),
    localparam int CNT_W        = $clog2(NUM_ENTRIES) + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    input  logic [1:0][31:0]      req_addr,
    input  logic [1:0]            req_prefetch,
    output logic [1:0]            req_ready,
    input  logic                  squash_prefetch,
    output logic [CNT_W-1:0]      mshr_free_slots,
    output logic                  mem_req_valid,
    output logic [31:0]           mem_req_addr,
    output logic [1:0]            mem_req_command,
    input  logic [TAG_W-1:0]      Imem2proc_transaction_tag,
    input  logic [BLOCK_W-1:0]    Imem2proc_data,
    input  logic [TAG_W-1:0]      Imem2proc_data_tag,
    output logic                  write_valid,
    output logic [31:0]           write_addr,
    output logic [BLOCK_W-1:0]    write_data
);

    localparam logic [1:0] MEM_NONE = 2'h0;
    localparam logic [1:0] MEM_LOAD = 2'h1;

    typedef enum logic [1:0] {
        ST_INVALID,
        ST_PENDING,
        ST_ISSUED
    } state_e;

    typedef logic [NUM_ENTRIES-1:0] vec_t;

    state_e [NUM_ENTRIES-1:0]            state_q, state_d;
    logic   [NUM_ENTRIES-1:0][28:0]      line_q, line_d;
    vec_t                                pf_q, pf_d;
    logic   [NUM_ENTRIES-1:0][TAG_W-1:0] tag_q, tag_d;

    logic               write_valid_q, write_valid_d;
    logic [31:0]        write_addr_q, write_addr_d;
    logic [BLOCK_W-1:0] write_data_q, write_data_d;

    logic [28:0] line0, line1;
    vec_t        hit0, hit1, free, free1;
    vec_t        alloc0, alloc1, promote;
    vec_t        pend_dem, pend_pf, pick;
    vec_t        fill_hit, fill;
    logic        same, pf0;
    logic        unused_low_bits;

    assign unused_low_bits = ^{req_addr[0][2:0], req_addr[1][2:0]};

    function automatic vec_t lowest(input vec_t v);
        return v & (~v + vec_t'(1));
    endfunction

    always_comb begin
        line0    = req_addr[0][31:3];
        line1    = req_addr[1][31:3];
        hit0     = '0;
        hit1     = '0;
        free     = '0;
        pend_dem = '0;
        pend_pf  = '0;
        fill_hit = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            free[i]     = state_q[i] == ST_INVALID;
            hit0[i]     = !free[i] && line_q[i] == line0;
            hit1[i]     = !free[i] && line_q[i] == line1;
            pend_dem[i] = state_q[i] == ST_PENDING && !pf_q[i];
            pend_pf[i]  = state_q[i] == ST_PENDING && pf_q[i];
            fill_hit[i] = state_q[i] == ST_ISSUED
                       && Imem2proc_data_tag != '0
                       && tag_q[i] == Imem2proc_data_tag;
        end
        pick = (|pend_dem) ? lowest(pend_dem) : lowest(pend_pf);
        fill = lowest(fill_hit);
    end

    // Only entries free at cycle start are allocatable; port 0 picks first.
    always_comb begin
        req_ready = '0;
        alloc0    = '0;
        alloc1    = '0;
        same      = req_valid[0] && line1 == line0;
        if (req_valid[0]) begin
            if (|hit0) begin
                req_ready[0] = 1'b1;
            end else if (|free) begin
                req_ready[0] = 1'b1;
                alloc0       = lowest(free);
            end
        end
        free1 = free & ~alloc0;
        if (req_valid[1]) begin
            if ((|hit1) || same) begin
                req_ready[1] = 1'b1;
            end else if (|free1) begin
                req_ready[1] = 1'b1;
                alloc1       = lowest(free1);
            end
        end
        promote = (hit0 & {NUM_ENTRIES{req_valid[0] && !req_prefetch[0]}})
                | (hit1 & {NUM_ENTRIES{req_valid[1] && !req_prefetch[1]}});
        pf0 = req_prefetch[0] && !(req_valid[1] && same && !req_prefetch[1]);
    end

    // An accepted tag beats a squash; a promoted entry escapes the squash.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        pf_d    = pf_q;
        tag_d   = tag_q;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (fill[i]) begin
                state_d[i] = ST_INVALID;
            end else if (pick[i] && Imem2proc_transaction_tag != '0) begin
                state_d[i] = ST_ISSUED;
                tag_d[i]   = Imem2proc_transaction_tag;
            end else if (squash_prefetch && state_q[i] == ST_PENDING
                         && pf_q[i] && !promote[i]) begin
                state_d[i] = ST_INVALID;
            end
            if (promote[i] && state_q[i] == ST_PENDING) begin
                pf_d[i] = 1'b0;
            end
            if (alloc0[i]) begin
                state_d[i] = ST_PENDING;
                line_d[i]  = line0;
                pf_d[i]    = pf0;
            end
            if (alloc1[i]) begin
                state_d[i] = ST_PENDING;
                line_d[i]  = line1;
                pf_d[i]    = req_prefetch[1];
            end
        end
    end

    always_comb begin
        mem_req_valid   = |pick;
        mem_req_command = mem_req_valid ? MEM_LOAD : MEM_NONE;
        mem_req_addr    = '0;
        mshr_free_slots = '0;
        write_valid_d   = |fill;
        write_addr_d    = write_addr_q;
        write_data_d    = write_data_q;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (pick[i]) begin
                mem_req_addr = {line_q[i], 3'b000};
            end
            if (fill[i]) begin
                write_addr_d = {line_q[i], 3'b000};
            end
            mshr_free_slots = mshr_free_slots + CNT_W'(free[i]);
        end
        if (|fill) begin
            write_data_d = Imem2proc_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                state_q[i] <= ST_INVALID;
            end
            line_q        <= '0;
            pf_q          <= '0;
            tag_q         <= '0;
            write_valid_q <= 1'b0;
            write_addr_q  <= '0;
            write_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            line_q        <= line_d;
            pf_q          <= pf_d;
            tag_q         <= tag_d;
            write_valid_q <= write_valid_d;
            write_addr_q  <= write_addr_d;
            write_data_q  <= write_data_d;
        end
    end

    assign write_valid = write_valid_q;
    assign write_addr  = write_addr_q;
    assign write_data  = write_data_q;

endmodule

// File: tb/tb_icache_mshr.sv
// Scoreboard bench for icache_mshr: expected memory requests and fills
// are queued when stimulus is driven and popped as the DUT produces them.
module tb_icache_mshr;

    localparam int TW = 4;
    localparam int BW = 64;

    typedef struct packed {
        logic [31:0]   addr;
        logic [BW-1:0] data;
    } fill_t;

    logic              clock = 1'b0;
    logic              reset;
    logic [1:0]        req_valid;
    logic [1:0][31:0]  req_addr;
    logic [1:0]        req_prefetch;
    logic [1:0]        req_ready;
    logic              squash_prefetch;
    logic [2:0]        mshr_free_slots;
    logic              mem_req_valid;
    logic [31:0]       mem_req_addr;
    logic [1:0]        mem_req_command;
    logic [TW-1:0]     Imem2proc_transaction_tag;
    logic [BW-1:0]     Imem2proc_data;
    logic [TW-1:0]     Imem2proc_data_tag;
    logic              write_valid;
    logic [31:0]       write_addr;
    logic [BW-1:0]     write_data;

    logic [31:0] mem_q[$];
    fill_t       fill_q[$];
    fill_t       exp_f;
    logic [31:0] exp_a;
    int          n_checks = 0;
    int          n_fail = 0;

    icache_mshr #(.NUM_ENTRIES(4), .NUM_MEM_TAGS(15), .BLOCK_W(BW)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr),
        .req_prefetch(req_prefetch), .req_ready(req_ready),
        .squash_prefetch(squash_prefetch),
        .mshr_free_slots(mshr_free_slots),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_command(mem_req_command),
        .Imem2proc_transaction_tag(Imem2proc_transaction_tag),
        .Imem2proc_data(Imem2proc_data),
        .Imem2proc_data_tag(Imem2proc_data_tag),
        .write_valid(write_valid), .write_addr(write_addr),
        .write_data(write_data)
    );

    initial forever #5 clock = ~clock;

    function automatic logic [BW-1:0] pat(input int t);
        return 64'hC0DE_0000_0000_0000 | 64'(t);
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic idle();
        req_valid = '0;
        req_addr = '0;
        req_prefetch = '0;
        squash_prefetch = 1'b0;
        Imem2proc_transaction_tag = '0;
        Imem2proc_data = '0;
        Imem2proc_data_tag = '0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        cyc();
        cyc();
        mid();
        n_checks++; if (mshr_free_slots !== 3'd4) begin n_fail++; $display("FAIL rst_free got %0d want 4", mshr_free_slots); end
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_memv got %b want 0", mem_req_valid); end
        n_checks++; if (mem_req_command !== 2'h0) begin n_fail++; $display("FAIL rst_cmd got %h want 0", mem_req_command); end
        n_checks++; if (write_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wv got %b want 0", write_valid); end
        n_checks++; if (write_addr !== 32'h0) begin n_fail++; $display("FAIL rst_wa got %h want 0", write_addr); end
        n_checks++; if (write_data !== 64'h0) begin n_fail++; $display("FAIL rst_wd got %h want 0", write_data); end
        cyc();
        reset = 1'b1;
    endtask

    task automatic test_single_demand();
        cyc();
        req_valid = 2'b01; req_addr[0] = 32'h100; req_prefetch = 2'b00;
        mid();
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL sd_ready got %b want 01", req_ready); end
        n_checks++; if (mshr_free_slots !== 3'd4) begin n_fail++; $display("FAIL sd_free0 got %0d want 4", mshr_free_slots); end
        mem_q.push_back(32'h100);
        cyc();
        idle(); Imem2proc_transaction_tag = 4'd3;
        mid();
        exp_a = mem_q.pop_front();
        n_checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== exp_a) begin n_fail++; $display("FAIL sd_memreq got v=%b a=%h want v=1 a=%h", mem_req_valid, mem_req_addr, exp_a); end
        n_checks++; if (mem_req_command !== 2'h1) begin n_fail++; $display("FAIL sd_cmd got %h want 1", mem_req_command); end
        n_checks++; if (mshr_free_slots !== 3'd3) begin n_fail++; $display("FAIL sd_free1 got %0d want 3", mshr_free_slots); end
        fill_q.push_back('{addr: 32'h100, data: 64'hDEAD});
        cyc();
        idle();
        mid();
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL sd_issued got %b want 0", mem_req_valid); end
        cyc();
        cyc();
        cyc();
        Imem2proc_data_tag = 4'd3; Imem2proc_data = 64'hDEAD;
        cyc();
        idle();
        mid();
        exp_f = fill_q.pop_front();
        n_checks++; if (write_valid !== 1'b1 || write_addr !== exp_f.addr || write_data !== exp_f.data) begin n_fail++; $display("FAIL sd_fill got v=%b a=%h d=%h want v=1 a=%h d=%h", write_valid, write_addr, write_data, exp_f.addr, exp_f.data); end
        n_checks++; if (mshr_free_slots !== 3'd4) begin n_fail++; $display("FAIL sd_free2 got %0d want 4", mshr_free_slots); end
        cyc();
        mid();
        n_checks++; if (write_valid !== 1'b0) begin n_fail++; $display("FAIL sd_strobe got %b want 0", write_valid); end
    endtask

    task automatic test_merge();
        cyc();
        req_valid = 2'b11; req_addr[0] = 32'h100; req_addr[1] = 32'h100;
        mid();
        n_checks++; if (req_ready !== 2'b11) begin n_fail++; $display("FAIL mg_ready0 got %b want 11", req_ready); end
        mem_q.push_back(32'h100);
        cyc();
        req_valid = 2'b01; req_addr[0] = 32'h104; Imem2proc_transaction_tag = 4'd4;
        mid();
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL mg_ready1 got %b want 01", req_ready); end
        n_checks++; if (mshr_free_slots !== 3'd3) begin n_fail++; $display("FAIL mg_free got %0d want 3", mshr_free_slots); end
        exp_a = mem_q.pop_front();
        n_checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== exp_a) begin n_fail++; $display("FAIL mg_memreq got v=%b a=%h want v=1 a=%h", mem_req_valid, mem_req_addr, exp_a); end
        fill_q.push_back('{addr: 32'h100, data: pat(4)});
        for (int k = 0; k < 2; k++) begin
            cyc();
            idle();
            mid();
            n_checks++; if (mem_req_valid !== 1'b0 || mshr_free_slots !== 3'd3) begin n_fail++; $display("FAIL mg_single got v=%b free=%0d want v=0 free=3", mem_req_valid, mshr_free_slots); end
        end
        cyc();
        Imem2proc_data_tag = 4'd4; Imem2proc_data = pat(4);
        cyc();
        idle();
        mid();
        exp_f = fill_q.pop_front();
        n_checks++; if (write_valid !== 1'b1 || write_addr !== exp_f.addr || write_data !== exp_f.data) begin n_fail++; $display("FAIL mg_fill got v=%b a=%h d=%h want v=1 a=%h d=%h", write_valid, write_addr, write_data, exp_f.addr, exp_f.data); end
        n_checks++; if (mshr_free_slots !== 3'd4) begin n_fail++; $display("FAIL mg_free2 got %0d want 4", mshr_free_slots); end
    endtask

    task automatic test_priority();
        cyc();
        req_valid = 2'b11; req_addr[0] = 32'h200; req_addr[1] = 32'h300; req_prefetch = 2'b01;
        mid();
        n_checks++; if (req_ready !== 2'b11) begin n_fail++; $display("FAIL pr_ready got %b want 11", req_ready); end
        mem_q.push_back(32'h300);
        mem_q.push_back(32'h200);
        cyc();
        idle();
        mid();
        n_checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== mem_q[0]) begin n_fail++; $display("FAIL pr_first got v=%b a=%h want v=1 a=%h", mem_req_valid, mem_req_addr, mem_q[0]); end
        cyc();
        req_valid = 2'b01; req_addr[0] = 32'h200; req_prefetch = 2'b00;
        mid();
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL pr_merge got %b want 01", req_ready); end
        n_checks++; if (mem_req_addr !== mem_q[0]) begin n_fail++; $display("FAIL pr_retry got %h want %h", mem_req_addr, mem_q[0]); end
        mem_q.push_front(mem_q.pop_back());
        for (int k = 0; k < 2; k++) begin
            cyc();
            idle(); Imem2proc_transaction_tag = TW'(6 + k);
            mid();
            exp_a = mem_q.pop_front();
            n_checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== exp_a) begin n_fail++; $display("FAIL pr_order%0d got v=%b a=%h want v=1 a=%h", k, mem_req_valid, mem_req_addr, exp_a); end
            fill_q.push_back('{addr: exp_a, data: pat(6 + k)});
        end
        cyc();
        idle(); Imem2proc_data_tag = 4'd6; Imem2proc_data = pat(6);
        mid();
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL pr_done got %b want 0", mem_req_valid); end
        for (int k = 0; k < 2; k++) begin
            cyc();
            Imem2proc_data_tag = (k == 0) ? 4'd7 : 4'd0; Imem2proc_data = pat(7);
            mid();
            exp_f = fill_q.pop_front();
            n_checks++; if (write_valid !== 1'b1 || write_addr !== exp_f.addr || write_data !== exp_f.data) begin n_fail++; $display("FAIL pr_fill%0d got v=%b a=%h d=%h want v=1 a=%h d=%h", k, write_valid, write_addr, write_data, exp_f.addr, exp_f.data); end
        end
        n_checks++; if (mshr_free_slots !== 3'd4) begin n_fail++; $display("FAIL pr_free got %0d want 4", mshr_free_slots); end
    endtask

    task automatic test_full_back_to_back();
        cyc();
        idle(); req_valid = 2'b11; req_addr[0] = 32'h400; req_addr[1] = 32'h500;
        mid();
        n_checks++; if (req_ready !== 2'b11) begin n_fail++; $display("FAIL fu_ready0 got %b want 11", req_ready); end
        mem_q.push_back(32'h400); mem_q.push_back(32'h500);
        cyc();
        req_addr[0] = 32'h600; req_addr[1] = 32'h700;
        mid();
        n_checks++; if (req_ready !== 2'b11) begin n_fail++; $display("FAIL fu_ready1 got %b want 11", req_ready); end
        n_checks++; if (mshr_free_slots !== 3'd2) begin n_fail++; $display("FAIL fu_free2 got %0d want 2", mshr_free_slots); end
        mem_q.push_back(32'h600); mem_q.push_back(32'h700);
        for (int k = 0; k < 4; k++) begin
            cyc();
            req_valid = 2'b01; req_addr[0] = 32'h800;
            mid();
            n_checks++; if (req_ready !== 2'b00 || mshr_free_slots !== 3'd0) begin n_fail++; $display("FAIL fu_full%0d got ready=%b free=%0d want ready=00 free=0", k, req_ready, mshr_free_slots); end
            n_checks++; if (mem_req_addr !== mem_q[0]) begin n_fail++; $display("FAIL fu_head%0d got %h want %h", k, mem_req_addr, mem_q[0]); end
        end
        for (int k = 0; k < 4; k++) begin
            cyc();
            idle(); Imem2proc_transaction_tag = TW'(k + 1);
            mid();
            exp_a = mem_q.pop_front();
            n_checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== exp_a) begin n_fail++; $display("FAIL fu_issue%0d got v=%b a=%h want v=1 a=%h", k, mem_req_valid, mem_req_addr, exp_a); end
            fill_q.push_back('{addr: exp_a, data: pat(k + 1)});
        end
        cyc();
        idle(); Imem2proc_data_tag = 4'd1; Imem2proc_data = pat(1);
        mid();
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL fu_no5th got v=%b a=%h want v=0", mem_req_valid, mem_req_addr); end
        for (int k = 0; k < 4; k++) begin
            cyc();
            Imem2proc_data_tag = (k < 3) ? TW'(k + 2) : '0; Imem2proc_data = pat(k + 2);
            mid();
            exp_f = fill_q.pop_front();
            n_checks++; if (write_valid !== 1'b1 || write_addr !== exp_f.addr || write_data !== exp_f.data) begin n_fail++; $display("FAIL fu_fill%0d got v=%b a=%h d=%h want v=1 a=%h d=%h", k, write_valid, write_addr, write_data, exp_f.addr, exp_f.data); end
        end
        cyc();
        mid();
        n_checks++; if (write_valid !== 1'b0 || mshr_free_slots !== 3'd4) begin n_fail++; $display("FAIL fu_end got v=%b free=%0d want v=0 free=4", write_valid, mshr_free_slots); end
    endtask

    task automatic test_squash();
        cyc();
        idle(); req_valid = 2'b01; req_addr[0] = 32'h900; req_prefetch = 2'b01;
        mid();
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL sq_ready0 got %b want 01", req_ready); end
        mem_q.push_back(32'h900);
        cyc();
        req_valid = 2'b11; req_addr[0] = 32'hA00; req_addr[1] = 32'hB00; req_prefetch = 2'b11;
        Imem2proc_transaction_tag = 4'd5;
        mid();
        n_checks++; if (req_ready !== 2'b11) begin n_fail++; $display("FAIL sq_ready1 got %b want 11", req_ready); end
        exp_a = mem_q.pop_front();
        n_checks++; if (mem_req_addr !== exp_a) begin n_fail++; $display("FAIL sq_issue got %h want %h", mem_req_addr, exp_a); end
        fill_q.push_back('{addr: 32'h900, data: pat(5)});
        mem_q.push_back(32'hA00); mem_q.push_back(32'hB00);
        cyc();
        idle();
        mid();
        n_checks++; if (mshr_free_slots !== 3'd1 || mem_req_addr !== mem_q[0]) begin n_fail++; $display("FAIL sq_pend got free=%0d a=%h want free=1 a=%h", mshr_free_slots, mem_req_addr, mem_q[0]); end
        cyc();
        squash_prefetch = 1'b1;
        mid();
        n_checks++; if (mshr_free_slots !== 3'd1) begin n_fail++; $display("FAIL sq_before got %0d want 1", mshr_free_slots); end
        mem_q.delete();
        cyc();
        idle();
        mid();
        n_checks++; if (mshr_free_slots !== 3'd3) begin n_fail++; $display("FAIL sq_after got %0d want 3", mshr_free_slots); end
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL sq_memv got %b want 0", mem_req_valid); end
        cyc();
        Imem2proc_data_tag = 4'd5; Imem2proc_data = pat(5);
        cyc();
        idle();
        mid();
        exp_f = fill_q.pop_front();
        n_checks++; if (write_valid !== 1'b1 || write_addr !== exp_f.addr || write_data !== exp_f.data) begin n_fail++; $display("FAIL sq_fill got v=%b a=%h d=%h want v=1 a=%h d=%h", write_valid, write_addr, write_data, exp_f.addr, exp_f.data); end
        n_checks++; if (mshr_free_slots !== 3'd4) begin n_fail++; $display("FAIL sq_free got %0d want 4", mshr_free_slots); end
    endtask

    task automatic test_reset_midflight();
        cyc();
        idle(); req_valid = 2'b01; req_addr[0] = 32'hC00;
        mid();
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rm_ready got %b want 01", req_ready); end
        mem_q.push_back(32'hC00);
        cyc();
        idle(); Imem2proc_transaction_tag = 4'd2;
        mid();
        exp_a = mem_q.pop_front();
        n_checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== exp_a) begin n_fail++; $display("FAIL rm_memreq got v=%b a=%h want v=1 a=%h", mem_req_valid, mem_req_addr, exp_a); end
        cyc();
        idle(); reset = 1'b0;
        mid();
        n_checks++; if (mshr_free_slots !== 3'd3) begin n_fail++; $display("FAIL rm_issued got %0d want 3", mshr_free_slots); end
        cyc();
        reset = 1'b1;
        mid();
        n_checks++; if (mshr_free_slots !== 3'd4 || mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rm_cleared got free=%0d v=%b want free=4 v=0", mshr_free_slots, mem_req_valid); end
        cyc();
        Imem2proc_data_tag = 4'd2; Imem2proc_data = pat(2);
        cyc();
        idle();
        mid();
        n_checks++; if (write_valid !== 1'b0) begin n_fail++; $display("FAIL rm_stale got %b want 0", write_valid); end
        n_checks++; if (mshr_free_slots !== 3'd4) begin n_fail++; $display("FAIL rm_free got %0d want 4", mshr_free_slots); end
    endtask

    initial begin
        test_reset();
        test_single_demand();
        test_merge();
        test_priority();
        test_full_back_to_back();
        test_squash();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
